// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer.
//   rob_entry_t : per-entry control bits (valid, rdy, has_rd, rd, is_br);
//                 pc/data live in separate WIDTH-wide arrays in the top.
//   tag_width() : derives the tag width from the entry count.
//   age()       : distance of a tag from the head, modulo the entry count.
package rob_pkg;

  localparam int unsigned RD_W  = 5;
  localparam int unsigned AGE_W = 16;

  typedef struct packed {
    logic            valid;
    logic            rdy;
    logic            has_rd;
    logic [RD_W-1:0] rd;
    logic            is_br;
  } rob_entry_t;

  function automatic int unsigned tag_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // depth is a power of two, so masking with depth-1 is the modulo
  function automatic logic [AGE_W-1:0] age(input logic [AGE_W-1:0] tag,
                                           input logic [AGE_W-1:0] head,
                                           input int unsigned      depth);
    return (tag - head) & AGE_W'(depth - 1);
  endfunction

endpackage

// File: rtl/rob_flush_arbiter.sv
// Combinational oldest-mispredict select across the writeback ports.
//   cand_i : per-port candidate (accepted writeback, mispredict, entry is a branch)
//   tag_i  : per-port tags, packed N_WB*TAG_W
//   head_i : current head index
//   hit_o  : any candidate present
//   port_o : index of the winning port
//   tag_o  : tag of the winning port (oldest relative to head)
module rob_flush_arbiter
  import rob_pkg::*;
#(
  parameter int unsigned N_WB  = 3,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PORT_W = (N_WB > 1) ? $clog2(N_WB) : 1
) (
  input  logic [N_WB-1:0]       cand_i,
  input  logic [N_WB*TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0]      head_i,
  output logic                  hit_o,
  output logic [PORT_W-1:0]     port_o,
  output logic [TAG_W-1:0]      tag_o
);

  logic [AGE_W-1:0] best_age;
  logic [AGE_W-1:0] cur_age;
  logic [TAG_W-1:0] cur_tag;

  always_comb begin
    hit_o    = 1'b0;
    port_o   = '0;
    tag_o    = '0;
    best_age = '1;
    cur_age  = '0;
    cur_tag  = '0;
    for (int unsigned p = 0; p < N_WB; p++) begin
      cur_tag = tag_i[p*TAG_W +: TAG_W];
      cur_age = age(AGE_W'(cur_tag), AGE_W'(head_i), DEPTH);
      if (cand_i[p] && (!hit_o || cur_age < best_age)) begin
        hit_o    = 1'b1;
        port_o   = PORT_W'(p);
        tag_o    = cur_tag;
        best_age = cur_age;
      end
    end
  end

endmodule

// File: rtl/rob_multicommit.sv
// Reorder buffer with in-order allocation, N_WB writeback ports, up to
// N_COMMIT in-order retirements per cycle and mispredict flush.
//   alloc_*        : dispatch handshake; alloc_tag is the tail index
//   wb_*           : per-port results, mispredict flag and redirect PC
//   commit_*       : retire lanes, contiguous from lane 0
//   flush_*        : registered one-cycle flush pulse, first squashed tag, redirect PC
//   count          : occupied entries
module rob_multicommit
  import rob_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned N_WB     = 3,
  parameter int unsigned N_COMMIT = 2,
  localparam int unsigned TAG_W   = tag_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic                      alloc_has_rd,
  input  logic [4:0]                alloc_rd,
  input  logic [WIDTH-1:0]          alloc_pc,
  input  logic                      alloc_is_br,
  output logic [TAG_W-1:0]          alloc_tag,
  input  logic [N_WB-1:0]           wb_valid,
  input  logic [N_WB*TAG_W-1:0]     wb_tag,
  input  logic [N_WB*WIDTH-1:0]     wb_data,
  input  logic [N_WB-1:0]           wb_mispredict,
  input  logic [N_WB*WIDTH-1:0]     wb_redirect,
  output logic [N_COMMIT-1:0]       commit_valid,
  output logic [N_COMMIT-1:0]       commit_has_rd,
  output logic [N_COMMIT*5-1:0]     commit_rd,
  output logic [N_COMMIT*WIDTH-1:0] commit_data,
  output logic [N_COMMIT*TAG_W-1:0] commit_tag,
  output logic                      flush_valid,
  output logic [TAG_W-1:0]          flush_tag,
  output logic [WIDTH-1:0]          flush_pc,
  output logic [TAG_W:0]            count
);

  localparam int unsigned PORT_W = (N_WB > 1) ? $clog2(N_WB) : 1;
  localparam int unsigned PTR_W  = TAG_W + 1;
  localparam int unsigned CNT_W  = $clog2(N_COMMIT + 1);

  rob_entry_t       ent_q  [DEPTH];
  rob_entry_t       ent_d  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic             flush_valid_q;
  logic [TAG_W-1:0] flush_tag_q;
  logic [WIDTH-1:0] flush_pc_q;

  logic [TAG_W-1:0]  head_idx, tail_idx;
  logic              full;
  logic              alloc_fire;
  logic [TAG_W-1:0]  wtag   [N_WB];
  logic [N_WB-1:0]   wb_hit;
  logic [N_WB-1:0]   cand;
  logic [N_WB-1:0]   accept;
  logic              flush_now;
  logic [PORT_W-1:0] sel_port;
  logic [TAG_W-1:0]  sel_tag;
  logic [AGE_W-1:0]  sel_age;
  logic [CNT_W-1:0]  ncommit;
  logic              run;
  logic [TAG_W-1:0]  cidx;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign count    = tail_q - head_q;
  assign full     = (count == PTR_W'(DEPTH));

  // A port hits only a live entry; mispredict candidates must also be branches.
  always_comb begin
    wb_hit = '0;
    cand   = '0;
    for (int unsigned p = 0; p < N_WB; p++) begin
      wtag[p]   = wb_tag[p*TAG_W +: TAG_W];
      wb_hit[p] = wb_valid[p] && ent_q[wtag[p]].valid;
      cand[p]   = wb_hit[p] && wb_mispredict[p] && ent_q[wtag[p]].is_br;
    end
  end

  rob_flush_arbiter #(
    .N_WB  (N_WB),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) u_arb (
    .cand_i (cand),
    .tag_i  (wb_tag),
    .head_i (head_idx),
    .hit_o  (flush_now),
    .port_o (sel_port),
    .tag_o  (sel_tag)
  );

  assign sel_age = age(AGE_W'(sel_tag), AGE_W'(head_idx), DEPTH);

  // Results for entries younger than the selected mispredict are dropped.
  always_comb begin
    accept = '0;
    for (int unsigned p = 0; p < N_WB; p++) begin
      accept[p] = wb_hit[p] &&
                  (!flush_now || age(AGE_W'(wtag[p]), AGE_W'(head_idx), DEPTH) <= sel_age);
    end
  end

  assign alloc_ready = !full && !flush_now;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_idx;

  // Retire lanes: a lane is live only while every older lane is live too.
  always_comb begin
    commit_valid  = '0;
    commit_has_rd = '0;
    commit_rd     = '0;
    commit_data   = '0;
    commit_tag    = '0;
    ncommit       = '0;
    run           = 1'b1;
    cidx          = '0;
    for (int unsigned k = 0; k < N_COMMIT; k++) begin
      cidx = head_idx + TAG_W'(k);
      run  = run && ent_q[cidx].valid && ent_q[cidx].rdy;
      commit_valid[k]                 = run;
      commit_has_rd[k]                = ent_q[cidx].has_rd;
      commit_rd[k*5 +: 5]             = ent_q[cidx].rd;
      commit_data[k*WIDTH +: WIDTH]   = data_q[cidx];
      commit_tag[k*TAG_W +: TAG_W]    = cidx;
      if (run) ncommit = ncommit + CNT_W'(1);
    end
  end

  always_comb begin
    ent_d  = ent_q;
    data_d = data_q;
    for (int unsigned p = 0; p < N_WB; p++) begin
      if (accept[p]) begin
        ent_d[wtag[p]].rdy = 1'b1;
        data_d[wtag[p]]    = wb_data[p*WIDTH +: WIDTH];
      end
    end
    if (flush_now) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (age(AGE_W'(i), AGE_W'(head_idx), DEPTH) > sel_age) begin
          ent_d[i] = '0;
        end
      end
    end
    for (int unsigned k = 0; k < N_COMMIT; k++) begin
      if (commit_valid[k]) ent_d[head_idx + TAG_W'(k)] = '0;
    end
    if (alloc_fire) begin
      ent_d[tail_idx] = '{valid: 1'b1, rdy: 1'b0, has_rd: alloc_has_rd,
                          rd: alloc_rd, is_br: alloc_is_br};
    end
  end

  // New tail is rebuilt from head so the wrap bit stays consistent.
  always_comb begin
    head_d = head_q + PTR_W'(ncommit);
    if (flush_now)       tail_d = head_q + PTR_W'(sel_age) + PTR_W'(1);
    else if (alloc_fire) tail_d = tail_q + PTR_W'(1);
    else                 tail_d = tail_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      flush_valid_q <= 1'b0;
      flush_tag_q   <= '0;
      flush_pc_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      ent_q         <= ent_d;
      flush_valid_q <= flush_now;
      if (flush_now) begin
        flush_tag_q <= sel_tag + TAG_W'(1);
        flush_pc_q  <= wb_redirect[sel_port*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (alloc_fire) pc_q[tail_idx] <= alloc_pc;
  end

  // Entry PC is held for later exception reporting; nothing consumes it yet.
  logic unused_pc;
  always_comb begin
    unused_pc = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) unused_pc = unused_pc ^ (^pc_q[i]);
  end

  assign flush_valid = flush_valid_q;
  assign flush_tag   = flush_tag_q;
  assign flush_pc    = flush_pc_q;

  // Two ports writing the same tag in one cycle is illegal.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned p = 0; p < N_WB; p++) begin
        for (int unsigned q = p + 1; q < N_WB; q++) begin
          assert (!(wb_valid[p] && wb_valid[q] && wtag[p] == wtag[q]));
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multicommit.sv
module tb_rob_multicommit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int N_WB  = 3;
  localparam int NC    = 2;
  localparam int TW    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alloc_valid, alloc_ready, alloc_has_rd, alloc_is_br;
  logic [4:0]        alloc_rd;
  logic [WIDTH-1:0]  alloc_pc;
  logic [TW-1:0]     alloc_tag;
  logic [N_WB-1:0]   wb_valid, wb_mispredict;
  logic [N_WB*TW-1:0]    wb_tag;
  logic [N_WB*WIDTH-1:0] wb_data, wb_redirect;
  logic [NC-1:0]     commit_valid, commit_has_rd;
  logic [NC*5-1:0]   commit_rd;
  logic [NC*WIDTH-1:0] commit_data;
  logic [NC*TW-1:0]  commit_tag;
  logic              flush_valid;
  logic [TW-1:0]     flush_tag;
  logic [WIDTH-1:0]  flush_pc;
  logic [TW:0]       count;

  rob_multicommit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_WB(N_WB), .N_COMMIT(NC)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_has_rd(alloc_has_rd),
    .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_is_br(alloc_is_br), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_redirect(wb_redirect),
    .commit_valid(commit_valid), .commit_has_rd(commit_has_rd), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .flush_valid(flush_valid), .flush_tag(flush_tag), .flush_pc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: in-flight queue, oldest first ----------------
  typedef struct {
    logic        has_rd;
    logic [4:0]  rd;
    logic        is_br;
    logic        rdy;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  int          mhead = 0;
  logic        mfv = 1'b0;
  int          mft = 0;
  logic [31:0] mfpc = '0;

  function automatic int mpos(input int t);
    int a;
    a = (t - mhead + DEPTH) % DEPTH;
    return (a < mq.size()) ? a : -1;
  endfunction

  always @(negedge clk) begin
    int sel, selp, pos, n, t;
    logic e_ready;
    if (rst) begin
      mq.delete();
      mhead = 0;
      mfv   = 1'b0;
      mft   = 0;
      mfpc  = '0;
    end else begin
      sel = -1; selp = 0;
      for (int p = 0; p < N_WB; p++) begin
        if (wb_valid[p]) begin
          t   = int'(wb_tag[p*TW +: TW]);
          pos = mpos(t);
          if (pos >= 0 && wb_mispredict[p] && mq[pos].is_br && (sel < 0 || pos < sel)) begin
            sel  = pos;
            selp = p;
          end
        end
      end
      e_ready = (mq.size() < DEPTH) && (sel < 0);
      chk("alloc_ready", alloc_ready, e_ready);
      chk("alloc_tag", alloc_tag, (mhead + mq.size()) % DEPTH);
      chk("count", count, mq.size());
      n = 0;
      while (n < NC && n < mq.size() && mq[n].rdy) n++;
      chk("commit_valid", commit_valid, (1 << n) - 1);
      for (int k = 0; k < n; k++) begin
        chk($sformatf("commit_tag[%0d]", k), commit_tag[k*TW +: TW], (mhead + k) % DEPTH);
        chk($sformatf("commit_has_rd[%0d]", k), commit_has_rd[k], mq[k].has_rd);
        chk($sformatf("commit_rd[%0d]", k), commit_rd[k*5 +: 5], mq[k].rd);
        chk($sformatf("commit_data[%0d]", k), commit_data[k*WIDTH +: WIDTH], mq[k].data);
      end
      chk("flush_valid", flush_valid, mfv);
      if (mfv) begin
        chk("flush_tag", flush_tag, mft);
        chk("flush_pc", flush_pc, mfpc);
      end
      // advance model
      for (int p = 0; p < N_WB; p++) begin
        if (wb_valid[p]) begin
          pos = mpos(int'(wb_tag[p*TW +: TW]));
          if (pos >= 0 && (sel < 0 || pos <= sel)) begin
            mq[pos].rdy  = 1'b1;
            mq[pos].data = wb_data[p*WIDTH +: WIDTH];
          end
        end
      end
      mfv = (sel >= 0);
      if (sel >= 0) begin
        mft  = (mhead + sel + 1) % DEPTH;
        mfpc = wb_redirect[selp*WIDTH +: WIDTH];
        while (mq.size() > sel + 1) void'(mq.pop_back());
      end
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      mhead = (mhead + n) % DEPTH;
      if (alloc_valid && e_ready)
        mq.push_back('{has_rd: alloc_has_rd, rd: alloc_rd, is_br: alloc_is_br, rdy: 1'b0, data: '0});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_has_rd = 0; alloc_rd = '0; alloc_pc = '0; alloc_is_br = 0;
    wb_valid = '0; wb_mispredict = '0; wb_tag = '0; wb_data = '0; wb_redirect = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic set_alloc(input logic hr, input logic [4:0] rd, input logic [31:0] pc, input logic br);
    alloc_valid = 1; alloc_has_rd = hr; alloc_rd = rd; alloc_pc = pc; alloc_is_br = br;
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] d,
                        input logic mis, input logic [31:0] redir);
    wb_valid[p]                 = 1'b1;
    wb_tag[p*TW +: TW]          = TW'(tag);
    wb_data[p*WIDTH +: WIDTH]   = d;
    wb_mispredict[p]            = mis;
    wb_redirect[p*WIDTH +: WIDTH] = redir;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush_valid", flush_valid, 0);

    // fill all eight slots
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1'b1, 5'(i + 1), 32'h100 + 32'(4 * i), 1'b0);
      #1;
      chk("fill_alloc_tag", alloc_tag, i);
      tick();
    end
    idle();
    #1;
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_count", count, 8);

    // three results in one cycle, two retire then one
    set_wb(0, 0, 32'hA0, 0, 0); set_wb(1, 1, 32'hA1, 0, 0); set_wb(2, 2, 32'hA2, 0, 0);
    tick(); idle(); #1;
    chk("c2_valid", commit_valid, 2'b11);
    chk("c2_tag0", commit_tag[0 +: TW], 0);
    chk("c2_tag1", commit_tag[TW +: TW], 1);
    chk("c2_data1", commit_data[WIDTH +: WIDTH], 32'hA1);
    tick(); #1;
    chk("c1_valid", commit_valid, 2'b01);
    chk("c1_tag0", commit_tag[0 +: TW], 2);
    chk("c1_data0", commit_data[0 +: WIDTH], 32'hA2);
    tick(); #1;
    chk("after_commit_count", count, 5);

    // younger ready entry waits for the head
    set_wb(0, 4, 32'hB4, 0, 0);
    tick(); idle(); #1;
    chk("blocked_valid", commit_valid, 0);
    tick(); #1;
    chk("blocked_valid2", commit_valid, 0);
    set_wb(1, 3, 32'hB3, 0, 0);
    tick(); idle(); #1;
    chk("unblock_valid", commit_valid, 2'b11);
    chk("unblock_tag0", commit_tag[0 +: TW], 3);
    chk("unblock_tag1", commit_tag[TW +: TW], 4);
    chk("unblock_data1", commit_data[WIDTH +: WIDTH], 32'hB4);
    tick(); tick(); #1;
    chk("unblock_count", count, 3);

    // two mispredicts in one cycle: the older one wins
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(1'b1, 5'(i + 1), 32'h400 + 32'(4 * i), (i == 2 || i == 4));
      tick();
    end
    idle();
    set_wb(0, 4, 32'h0, 1, 32'h40);
    set_wb(1, 2, 32'h22, 1, 32'h80);
    set_wb(2, 5, 32'h55, 0, 0);
    set_alloc(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("flushcyc_alloc_ready", alloc_ready, 0);
    tick(); idle(); #1;
    chk("flush_valid", flush_valid, 1);
    chk("flush_tag", flush_tag, 3);
    chk("flush_pc", flush_pc, 32'h80);
    chk("flush_count", count, 3);
    chk("flush_alloc_tag", alloc_tag, 3);
    tick(); #1;
    chk("flush_pulse_end", flush_valid, 0);
    set_wb(0, 0, 32'hC0, 0, 0); set_wb(1, 1, 32'hC1, 0, 0);
    tick(); idle(); #1;
    chk("postflush_valid", commit_valid, 2'b11);
    tick(); #1;
    chk("postflush_br_tag", commit_tag[0 +: TW], 2);
    chk("postflush_br_data", commit_data[0 +: WIDTH], 32'h22);
    tick(); #1;
    chk("postflush_count", count, 0);

    // mispredict on the newest entry still pulses
    set_alloc(1'b0, 5'd0, 32'h200, 1'b1);
    tick(); idle();
    set_wb(2, 3, 32'h33, 1, 32'h300);
    tick(); idle(); #1;
    chk("newest_flush_valid", flush_valid, 1);
    chk("newest_flush_tag", flush_tag, 4);
    chk("newest_flush_pc", flush_pc, 32'h300);
    chk("newest_count", count, 1);
    tick(); tick(); #1;
    chk("newest_drained", count, 0);

    // wrap: move head to 6 then run tags 6,7,0,1
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(1'b1, 5'(i + 10), 32'h0, 1'b0);
      tick();
    end
    idle();
    set_wb(0, 0, 32'h10, 0, 0); set_wb(1, 1, 32'h11, 0, 0); set_wb(2, 2, 32'h12, 0, 0);
    tick(); idle();
    set_wb(0, 3, 32'h13, 0, 0); set_wb(1, 4, 32'h14, 0, 0); set_wb(2, 5, 32'h15, 0, 0);
    tick(); idle();
    tick(); tick(); #1;
    chk("wrap_pre_count", count, 0);
    for (int i = 0; i < 4; i++) begin
      set_alloc(1'b1, 5'(i + 20), 32'h0, 1'b0);
      #1;
      chk("wrap_alloc_tag", alloc_tag, (6 + i) % DEPTH);
      tick();
    end
    idle();
    set_wb(0, 6, 32'h66, 0, 0); set_wb(1, 7, 32'h77, 0, 0); set_wb(2, 0, 32'h88, 0, 0);
    tick(); idle();
    set_wb(0, 1, 32'h99, 0, 0);
    #1;
    chk("wrap_c_tag0", commit_tag[0 +: TW], 6);
    chk("wrap_c_tag1", commit_tag[TW +: TW], 7);
    tick(); idle(); #1;
    chk("wrap_c2_valid", commit_valid, 2'b11);
    chk("wrap_c2_tag0", commit_tag[0 +: TW], 0);
    chk("wrap_c2_data1", commit_data[WIDTH +: WIDTH], 32'h99);
    tick(); #1;
    chk("wrap_count", count, 0);

    // full with commits and an allocation request in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(1'b1, 5'(i + 1), 32'h0, 1'b0);
      #1;
      chk("full2_alloc_tag", alloc_tag, (2 + i) % DEPTH);
      tick();
    end
    idle();
    set_wb(0, 2, 32'hD2, 0, 0); set_wb(1, 3, 32'hD3, 0, 0);
    tick(); idle();
    set_alloc(1'b1, 5'd9, 32'h500, 1'b1);
    #1;
    chk("fullcommit_valid", commit_valid, 2'b11);
    chk("fullcommit_alloc_ready", alloc_ready, 0);
    tick(); #1;
    chk("fullcommit_count", count, 6);
    chk("fullcommit_ready", alloc_ready, 1);
    chk("fullcommit_alloc_tag", alloc_tag, 2);
    tick(); idle(); #1;
    chk("refill_count", count, 7);

    // reset while the flush pulse is high
    set_wb(0, 2, 32'h0, 1, 32'h99);
    tick(); idle(); #1;
    chk("midflush_valid", flush_valid, 1);
    chk("midflush_tag", flush_tag, 3);
    rst = 1;
    tick(); #1;
    chk("rst_flush_cleared", flush_valid, 0);
    chk("rst_count_cleared", count, 0);
    rst = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
